// File: rtl/mux_alu_sequencer.sv
// -----------------------------------------------------------------------------
// mux_alu_sequencer
//
// Shares one 4-bit arithmetic/BCD datapath between two requesters.
// Requests are arbitrated round-robin in IDLE. The winner's operands and
// function select are latched onto the datapath inputs and held for a settle
// window. The datapath result is then captured and announced with a one-cycle
// valid strobe tagged with the owning requester.
//
// Parameters
//   SETTLE_CYCLES  cycles dp_* are held stable before dp_y is sampled
//                  (values below 1 behave as 1)
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   reqN/opN/aN/bN/mN   requester N request, function select, operands, mode
//   gnt0, gnt1          combinational accept strobes, IDLE only
//   dp_a/dp_b/dp_m      registered datapath operands and mode
//   dp_s0/dp_s1         registered datapath function selects (opN[0]/opN[1])
//   dp_y                datapath result
//   result              captured result, held until the next capture
//   result_valid        one-cycle strobe marking a new result
//   result_id           requester that owns result
//   busy                high whenever the sequencer is not IDLE
// -----------------------------------------------------------------------------
module mux_alu_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [1:0] op0,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic       m0,
  input  logic       req1,
  input  logic [1:0] op1,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  input  logic       m1,
  output logic       gnt0,
  output logic       gnt1,
  output logic [3:0] dp_a,
  output logic [3:0] dp_b,
  output logic       dp_m,
  output logic       dp_s0,
  output logic       dp_s1,
  input  logic [7:0] dp_y,
  output logic [7:0] result,
  output logic       result_valid,
  output logic       result_id,
  output logic       busy
);

  localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int CNT_W      = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_EFF - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DONE
  } state_t;

  state_t           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic             last_q,      last_d;
  logic             pend_id_q,   pend_id_d;
  logic [3:0]       dp_a_q,      dp_a_d;
  logic [3:0]       dp_b_q,      dp_b_d;
  logic             dp_m_q,      dp_m_d;
  logic [1:0]       dp_op_q,     dp_op_d;
  logic [7:0]       result_q,    result_d;
  logic             result_id_q, result_id_d;

  logic win_valid;
  logic win_id;

  // A tie goes to the requester that did not win last time.
  assign win_valid = req0 | req1;
  assign win_id    = (req0 & req1) ? ~last_q : req1;

  // NOTE: every variable assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    pend_id_d   = pend_id_q;
    dp_a_d      = dp_a_q;
    dp_b_d      = dp_b_q;
    dp_m_d      = dp_m_q;
    dp_op_d     = dp_op_q;
    result_d    = result_q;
    result_id_d = result_id_q;
    gnt0        = 1'b0;
    gnt1        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Reset takes precedence, so no grant is issued in a reset cycle.
        if (win_valid && !reset) begin
          gnt0      = ~win_id;
          gnt1      = win_id;
          dp_a_d    = win_id ? a1  : a0;
          dp_b_d    = win_id ? b1  : b0;
          dp_m_d    = win_id ? m1  : m0;
          dp_op_d   = win_id ? op1 : op0;
          last_d    = win_id;
          pend_id_d = win_id;
          cnt_d     = CNT_LOAD;
          state_d   = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        // dp_y is only trusted once the full settle window has elapsed.
        if (cnt_q == '0) begin
          result_d    = dp_y;
          result_id_d = pend_id_q;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the values from before this edge regardless of process order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b1;
      pend_id_q   <= 1'b0;
      dp_a_q      <= '0;
      dp_b_q      <= '0;
      dp_m_q      <= 1'b0;
      dp_op_q     <= '0;
      result_q    <= '0;
      result_id_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      pend_id_q   <= pend_id_d;
      dp_a_q      <= dp_a_d;
      dp_b_q      <= dp_b_d;
      dp_m_q      <= dp_m_d;
      dp_op_q     <= dp_op_d;
      result_q    <= result_d;
      result_id_q <= result_id_d;
    end
  end

  assign dp_a         = dp_a_q;
  assign dp_b         = dp_b_q;
  assign dp_m         = dp_m_q;
  assign dp_s0        = dp_op_q[0];
  assign dp_s1        = dp_op_q[1];
  assign result       = result_q;
  assign result_id    = result_id_q;
  assign result_valid = (state_q == ST_DONE);
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mux_alu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mux_alu_sequencer
//
// Main instance (SETTLE_CYCLES=2) is checked cycle by cycle against a
// transaction-level reference model: grant slots, round-robin pointer and the
// expected result stream. Expected results go into a scoreboard queue that an
// independent monitor drains whenever result_valid is seen. Two extra
// instances (SETTLE_CYCLES=4 and 0) check the latency rules.
// -----------------------------------------------------------------------------
module tb_mux_alu_sequencer;

  localparam int S = 2;

  typedef struct {
    logic [7:0] res;
    logic       id;
    int         vcyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1, m0, m1;
  logic [1:0] op0, op1;
  logic [3:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, dp_m, dp_s0, dp_s1, result_valid, result_id, busy;
  logic [3:0] dp_a, dp_b;
  logic [7:0] dp_y, result;

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sb[$];

  // Reference model state
  logic       ptr;
  int         next_free;
  logic [3:0] ex_a, ex_b;
  logic       ex_m;
  logic [1:0] ex_op;
  logic       g0_now, g1_now;
  logic       auto_drop;
  logic       y_force;
  int         y_last_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath stub: {a,b}, or a forced pattern that is only correct in the
  // last settle cycle.
  always_comb begin
    if (y_force) dp_y = (cyc == y_last_cyc) ? 8'h42 : 8'hEE;
    else         dp_y = {dp_a, dp_b};
  end

  mux_alu_sequencer #(.SETTLE_CYCLES(S)) u_dut (
    .clk(clk), .reset(reset),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0), .m0(m0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1), .m1(m1),
    .gnt0(gnt0), .gnt1(gnt1),
    .dp_a(dp_a), .dp_b(dp_b), .dp_m(dp_m), .dp_s0(dp_s0), .dp_s1(dp_s1),
    .dp_y(dp_y), .result(result), .result_valid(result_valid),
    .result_id(result_id), .busy(busy)
  );

  // Latency instances: SETTLE_CYCLES=4 and SETTLE_CYCLES=0 share stimulus.
  logic       x_req0;
  logic [3:0] x_a, x_b;
  logic       x4_g0, x4_g1, x4_m, x4_s0, x4_s1, x4_rv, x4_id, x4_busy;
  logic       x0_g0, x0_g1, x0_m, x0_s0, x0_s1, x0_rv, x0_id, x0_busy;
  logic [3:0] x4_a, x4_b, x0_a, x0_b;
  logic [7:0] x4_res, x0_res;

  mux_alu_sequencer #(.SETTLE_CYCLES(4)) u_dut4 (
    .clk(clk), .reset(reset),
    .req0(x_req0), .op0(2'b01), .a0(x_a), .b0(x_b), .m0(1'b0),
    .req1(1'b0), .op1(2'b00), .a1(4'h0), .b1(4'h0), .m1(1'b0),
    .gnt0(x4_g0), .gnt1(x4_g1),
    .dp_a(x4_a), .dp_b(x4_b), .dp_m(x4_m), .dp_s0(x4_s0), .dp_s1(x4_s1),
    .dp_y({x4_a, x4_b}), .result(x4_res), .result_valid(x4_rv),
    .result_id(x4_id), .busy(x4_busy)
  );

  mux_alu_sequencer #(.SETTLE_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req0(x_req0), .op0(2'b01), .a0(x_a), .b0(x_b), .m0(1'b0),
    .req1(1'b0), .op1(2'b00), .a1(4'h0), .b1(4'h0), .m1(1'b0),
    .gnt0(x0_g0), .gnt1(x0_g1),
    .dp_a(x0_a), .dp_b(x0_b), .dp_m(x0_m), .dp_s0(x0_s0), .dp_s1(x0_s1),
    .dp_y({x0_a, x0_b}), .result(x0_res), .result_valid(x0_rv),
    .result_id(x0_id), .busy(x0_busy)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // One cycle of the reference model, evaluated mid-cycle.
  task automatic model_cycle();
    logic ebusy;
    logic w;
    g0_now = 1'b0;
    g1_now = 1'b0;
    if (reset) begin
      ptr       = 1'b1;
      next_free = cyc + 1;
      sb.delete();
      ex_a = '0; ex_b = '0; ex_m = 1'b0; ex_op = '0;
      check("gnt_in_reset", {gnt1, gnt0}, 2'b00);
    end else begin
      // One operation occupies S+2 cycles starting at its grant.
      ebusy = (cyc < next_free);
      check("busy", busy, ebusy);
      check("dp_regs", {dp_a, dp_b, dp_m, dp_s1, dp_s0},
            {ex_a, ex_b, ex_m, ex_op[1], ex_op[0]});
      if (!ebusy && (req0 || req1)) begin
        w = (req0 && req1) ? ~ptr : req1;
        ptr = w;
        g0_now = ~w;
        g1_now = w;
        ex_a  = w ? a1 : a0;
        ex_b  = w ? b1 : b0;
        ex_m  = w ? m1 : m0;
        ex_op = w ? op1 : op0;
        y_last_cyc = cyc + S;
        sb.push_back('{res: y_force ? 8'h42 : {ex_a, ex_b}, id: w,
                       vcyc: cyc + S + 1});
        next_free = cyc + S + 2;
      end
      check("gnt", {gnt1, gnt0}, {g1_now, g0_now});
    end
  endtask

  // Latency-instance samples
  logic       s4_g, s0_g, s4_v, s0_v;
  logic [7:0] s4_r, s0_r;

  task automatic step();
    @(negedge clk);
    model_cycle();
    s4_g = x4_g0; s4_v = x4_rv; s4_r = x4_res;
    s0_g = x0_g0; s0_v = x0_rv; s0_r = x0_res;
    @(posedge clk);
    #1;
    if (auto_drop) begin
      if (g0_now) req0 = 1'b0;
      if (g1_now) req1 = 1'b0;
    end
  endtask

  // Scoreboard monitor: independent of the stimulus process.
  logic [7:0] hold_r;
  logic       hold_id;
  logic       clr_pend = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      clr_pend = 1'b1;
    end else begin
      if (clr_pend) begin
        hold_r   = '0;
        hold_id  = 1'b0;
        clr_pend = 1'b0;
      end
      if (sb.size() > 0 && sb[0].vcyc < cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL missing_valid: expected at cycle %0d, still absent at %0d",
                 sb[0].vcyc, cyc);
        void'(sb.pop_front());
      end
      if (result_valid) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_valid at cycle %0d: result %h", cyc, result);
        end else begin
          e = sb.pop_front();
          check("valid_cycle", cyc, e.vcyc);
          hold_r  = e.res;
          hold_id = e.id;
        end
      end
      check("result", result, hold_r);
      check("result_id", result_id, hold_id);
    end
  end

  initial begin
    int k4, k0;
    reset = 1'b1;
    req0 = 0; req1 = 0; op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    m0 = 0; m1 = 0; x_req0 = 0; x_a = 0; x_b = 0;
    auto_drop = 1'b1; y_force = 1'b0; y_last_cyc = -1;
    ptr = 1'b1; next_free = 0;
    step(); step();
    reset = 1'b0;
    step();  // post-reset: everything zero

    // Single request from requester 0
    a0 = 4'h3; b0 = 4'h5; op0 = 2'b10; m0 = 1'b1; req0 = 1'b1;
    repeat (6) step();

    // Tie held continuously: grants alternate
    auto_drop = 1'b0;
    a0 = 4'h1; b0 = 4'h7; op0 = 2'b01; m0 = 1'b0;
    a1 = 4'h2; b1 = 4'h9; op1 = 2'b11; m1 = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    repeat (16) step();
    req0 = 1'b0; req1 = 1'b0; auto_drop = 1'b1;
    repeat (5) step();

    // Settle timing: only the last settle cycle's dp_y may be captured
    y_force = 1'b1;
    a0 = 4'hA; b0 = 4'hB; req0 = 1'b1;
    repeat (6) step();
    y_force = 1'b0;

    // Request from 1 during requester 0's settle window
    a0 = 4'h6; b0 = 4'h4; req0 = 1'b1;
    step();
    a1 = 4'hC; b1 = 4'hD; req1 = 1'b1;
    repeat (9) step();

    // Reset in the second settle cycle aborts the operation
    a0 = 4'h8; b0 = 4'h1; req0 = 1'b1;
    step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (2) step();
    a1 = 4'h5; b1 = 4'h5; req1 = 1'b1;
    repeat (5) step();
    req0 = 1'b1; req1 = 1'b1;
    repeat (10) step();
    // Tie immediately after reset goes to requester 0
    reset = 1'b1;
    step();
    reset = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    repeat (10) step();

    // Latency for SETTLE_CYCLES=4 and SETTLE_CYCLES=0
    for (int it = 0; it < 3; it++) begin
      x_a = 4'($urandom); x_b = 4'($urandom); x_req0 = 1'b1;
      step();
      check("x4_gnt", s4_g, 1'b1);
      check("x0_gnt", s0_g, 1'b1);
      x_req0 = 1'b0;
      k4 = -1; k0 = -1;
      for (int k = 1; k <= 8; k++) begin
        step();
        if (s4_v && k4 < 0) begin
          k4 = k;
          check("x4_result", s4_r, {x_a, x_b});
        end
        if (s0_v && k0 < 0) begin
          k0 = k;
          check("x0_result", s0_r, {x_a, x_b});
        end
      end
      check("x4_latency", k4, 5);
      check("x0_latency", k0, 2);
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if (!req0 && $urandom_range(1, 0) == 1) begin
        a0 = 4'($urandom); b0 = 4'($urandom); op0 = 2'($urandom);
        m0 = 1'($urandom); req0 = 1'b1;
      end
      if (!req1 && $urandom_range(1, 0) == 1) begin
        a1 = 4'($urandom); b1 = 4'($urandom); op1 = 2'($urandom);
        m1 = 1'($urandom); req1 = 1'b1;
      end
      step();
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (8) step();
    check("scoreboard_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
